// File: rtl/bsg_dmc_ui_adapter.sv
`default_nettype none
// ============================================================================
// Module   : bsg_dmc_ui_adapter
// Purpose  : Front-end for the DMC pearl's Xilinx-style app_* UI. Turns a
//            valid/ready command stream and a valid/ready write-data stream
//            into the app_en/app_rdy and app_wdf_* handshakes. Read bursts
//            are collected in a credit-protected FIFO, because
//            app_rd_data_valid cannot be backpressured, and are returned on
//            a valid/yumi interface.
// Ports    : clk_i, reset_i (async, active high)
//            req_*         : command stream in (valid/ready)
//            wdata_*/wmask : write beat stream in (valid/ready)
//            rdata_*       : read beat stream out (valid/yumi)
//            app_*         : DMC user interface
//            rd_overflow_o : sticky, a read beat arrived while FIFO was full
// Revision : 1.0 - initial release
// ============================================================================
module bsg_dmc_ui_adapter #(
  parameter int addr_width_p  = 28,
  parameter int data_width_p  = 32,
  parameter int burst_len_p   = 2,
  parameter int rd_fifo_els_p = 4
) (
  input  logic                      clk_i,
  input  logic                      reset_i,

  input  logic                      req_v_i,
  input  logic                      req_write_i,
  input  logic [addr_width_p-1:0]   req_addr_i,
  output logic                      req_ready_o,

  input  logic                      wdata_v_i,
  input  logic [data_width_p-1:0]   wdata_i,
  input  logic [data_width_p/8-1:0] wmask_i,
  output logic                      wdata_ready_o,

  output logic                      rdata_v_o,
  output logic [data_width_p-1:0]   rdata_o,
  output logic                      rdata_last_o,
  input  logic                      rdata_yumi_i,

  output logic [addr_width_p-1:0]   app_addr_o,
  output logic [2:0]                app_cmd_o,
  output logic                      app_en_o,
  input  logic                      app_rdy_i,

  output logic                      app_wdf_wren_o,
  output logic                      app_wdf_end_o,
  output logic [data_width_p-1:0]   app_wdf_data_o,
  output logic [data_width_p/8-1:0] app_wdf_mask_o,
  input  logic                      app_wdf_rdy_i,

  input  logic                      app_rd_data_valid_i,
  input  logic                      app_rd_data_end_i,
  input  logic [data_width_p-1:0]   app_rd_data_i,

  output logic                      rd_overflow_o
);

  localparam int credit_width = $clog2(rd_fifo_els_p + 1);
  localparam int ptr_width    = (rd_fifo_els_p > 1) ? $clog2(rd_fifo_els_p) : 1;
  localparam int beat_width   = (burst_len_p > 1) ? $clog2(burst_len_p) : 1;

  localparam logic [credit_width-1:0] burst_credits = credit_width'(burst_len_p);
  localparam logic [credit_width-1:0] fifo_depth    = credit_width'(rd_fifo_els_p);
  localparam logic [beat_width-1:0]   last_beat     = beat_width'(burst_len_p - 1);
  localparam logic [ptr_width-1:0]    last_slot     = ptr_width'(rd_fifo_els_p - 1);

  localparam logic [2:0] cmd_write = 3'b000;
  localparam logic [2:0] cmd_read  = 3'b001;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CMD   = 2'd1,
    WDATA = 2'd2
  } state_e;

  state_e                    state_r, state_n;
  logic [beat_width-1:0]     beat_r, beat_n;
  logic [addr_width_p-1:0]   addr_r;
  logic [2:0]                cmd_r;
  logic [credit_width-1:0]   credits_r, credits_n;

  logic [data_width_p:0]     mem_r [rd_fifo_els_p];
  logic [ptr_width-1:0]      wptr_r, rptr_r;
  logic [credit_width-1:0]   count_r;
  logic                      overflow_r;

  logic accept, reserve, in_wdata, wbeat;
  logic fifo_full, fifo_empty, push, pop;

  // --------------------------------------------------------------------------
  // Command side
  // --------------------------------------------------------------------------
  assign req_ready_o = (state_r == IDLE) && (credits_r >= burst_credits);
  assign accept      = req_v_i & req_ready_o;
  // Read bursts reserve their FIFO slots at acceptance, so the return data
  // always has somewhere to land.
  assign reserve     = accept & ~req_write_i;

  assign in_wdata    = (state_r == WDATA);
  assign wbeat       = in_wdata & wdata_v_i & app_wdf_rdy_i;

  always_comb begin
    state_n = state_r;
    beat_n  = beat_r;
    unique case (state_r)
      IDLE: begin
        if (accept) state_n = CMD;
      end
      CMD: begin
        if (app_rdy_i) begin
          if (cmd_r == cmd_write) begin
            state_n = WDATA;
            beat_n  = '0;
          end else begin
            state_n = IDLE;
          end
        end
      end
      WDATA: begin
        if (wbeat) begin
          if (beat_r == last_beat) begin
            state_n = IDLE;
            beat_n  = '0;
          end else begin
            beat_n  = beat_r + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r <= IDLE;
      beat_r  <= '0;
      addr_r  <= '0;
      cmd_r   <= '0;
    end else begin
      state_r <= state_n;
      beat_r  <= beat_n;
      if (accept) begin
        addr_r <= req_addr_i;
        cmd_r  <= req_write_i ? cmd_write : cmd_read;
      end
    end
  end

  assign app_en_o   = (state_r == CMD);
  assign app_addr_o = addr_r;
  assign app_cmd_o  = cmd_r;

  // Write beats pass straight through while in WDATA and are forced quiet
  // otherwise, so data can never overtake its command.
  assign wdata_ready_o  = in_wdata & app_wdf_rdy_i;
  assign app_wdf_wren_o = in_wdata & wdata_v_i;
  assign app_wdf_end_o  = in_wdata & wdata_v_i & (beat_r == last_beat);
  assign app_wdf_data_o = in_wdata ? wdata_i : '0;
  assign app_wdf_mask_o = in_wdata ? wmask_i : '0;

  // --------------------------------------------------------------------------
  // Read return FIFO and credits
  // --------------------------------------------------------------------------
  assign fifo_full  = (count_r == fifo_depth);
  assign fifo_empty = (count_r == '0);
  assign push       = app_rd_data_valid_i & ~fifo_full;
  // A yumi on an empty FIFO is ignored and must not mint a credit.
  assign pop        = rdata_yumi_i & ~fifo_empty;

  always_comb begin
    credits_n = credits_r;
    if (reserve) credits_n = credits_n - burst_credits;
    if (pop)     credits_n = credits_n + 1'b1;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      credits_r  <= fifo_depth;
      count_r    <= '0;
      wptr_r     <= '0;
      rptr_r     <= '0;
      overflow_r <= 1'b0;
    end else begin
      credits_r <= credits_n;
      if (push) wptr_r <= (wptr_r == last_slot) ? '0 : wptr_r + 1'b1;
      if (pop)  rptr_r <= (rptr_r == last_slot) ? '0 : rptr_r + 1'b1;
      if (push && !pop)      count_r <= count_r + 1'b1;
      else if (!push && pop) count_r <= count_r - 1'b1;
      if (app_rd_data_valid_i && fifo_full) overflow_r <= 1'b1;
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (push) mem_r[wptr_r] <= {app_rd_data_end_i, app_rd_data_i};
  end

  assign rdata_v_o     = ~fifo_empty;
  assign rdata_o       = mem_r[rptr_r][data_width_p-1:0];
  assign rdata_last_o  = mem_r[rptr_r][data_width_p];
  assign rd_overflow_o = overflow_r;

endmodule
`default_nettype wire

// File: tb/tb_bsg_dmc_ui_adapter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bsg_dmc_ui_adapter
// Purpose  : Directed self-checking bench for bsg_dmc_ui_adapter. Expected
//            write beats and read beats are queued when driven and compared
//            when the DUT presents them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bsg_dmc_ui_adapter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_v, req_write;
  logic [27:0] req_addr;
  logic        req_ready_o;
  logic        wdata_v;
  logic [31:0] wdata;
  logic [3:0]  wmask;
  logic        wdata_ready_o;
  logic        rdata_v_o;
  logic [31:0] rdata_o;
  logic        rdata_last_o;
  logic        rdata_yumi;
  logic [27:0] app_addr_o;
  logic [2:0]  app_cmd_o;
  logic        app_en_o;
  logic        app_rdy;
  logic        app_wdf_wren_o, app_wdf_end_o;
  logic [31:0] app_wdf_data_o;
  logic [3:0]  app_wdf_mask_o;
  logic        app_wdf_rdy;
  logic        rd_valid, rd_end;
  logic [31:0] rd_data;
  logic        rd_overflow_o;

  int compared   = 0;
  int mismatched = 0;

  logic [36:0] wq[$];  // {end, mask, data}
  logic [32:0] rq[$];  // {last, data}

  always #5 clk = ~clk;

  bsg_dmc_ui_adapter #(
    .addr_width_p(28), .data_width_p(32), .burst_len_p(2), .rd_fifo_els_p(4)
  ) dut (
    .clk_i(clk), .reset_i(reset),
    .req_v_i(req_v), .req_write_i(req_write), .req_addr_i(req_addr),
    .req_ready_o(req_ready_o),
    .wdata_v_i(wdata_v), .wdata_i(wdata), .wmask_i(wmask),
    .wdata_ready_o(wdata_ready_o),
    .rdata_v_o(rdata_v_o), .rdata_o(rdata_o), .rdata_last_o(rdata_last_o),
    .rdata_yumi_i(rdata_yumi),
    .app_addr_o(app_addr_o), .app_cmd_o(app_cmd_o), .app_en_o(app_en_o),
    .app_rdy_i(app_rdy),
    .app_wdf_wren_o(app_wdf_wren_o), .app_wdf_end_o(app_wdf_end_o),
    .app_wdf_data_o(app_wdf_data_o), .app_wdf_mask_o(app_wdf_mask_o),
    .app_wdf_rdy_i(app_wdf_rdy),
    .app_rd_data_valid_i(rd_valid), .app_rd_data_end_i(rd_end),
    .app_rd_data_i(rd_data),
    .rd_overflow_o(rd_overflow_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_beat();
    logic [36:0] exp;
    chk("wdf_wren", app_wdf_wren_o, 1);
    chk("wdata_ready", wdata_ready_o, 1);
    if (wq.size() == 0) begin
      chk("wq_empty", 1, 0);
    end else begin
      exp = wq.pop_front();
      chk("wdf_beat", {app_wdf_end_o, app_wdf_mask_o, app_wdf_data_o}, exp);
    end
  endtask

  task automatic do_write(input logic [27:0] a, input logic [31:0] d0,
                          input logic [31:0] d1, input logic [3:0] m);
    req_v = 1; req_write = 1; req_addr = a;
    #1 chk("wr_req_ready", req_ready_o, 1);
    step();
    req_v = 0;
    wdata_v = 1; wdata = d0; wmask = m;
    wq.push_back({1'b0, m, d0});
    #1;
    chk("wr_app_en", app_en_o, 1);
    chk("wr_app_cmd", app_cmd_o, 3'b000);
    chk("wr_app_addr", app_addr_o, a);
    chk("wr_no_early_wren", app_wdf_wren_o, 0);
    chk("wr_no_early_ready", wdata_ready_o, 0);
    step();
    #1;
    chk("wr_app_en_drop", app_en_o, 0);
    wr_beat();
    step();
    wdata = d1;
    wq.push_back({1'b1, m, d1});
    #1 wr_beat();
    step();
    wdata_v = 0;
    #1;
    chk("wr_done_wren", app_wdf_wren_o, 0);
    chk("wr_done_ready", req_ready_o, 1);
  endtask

  task automatic issue_read(input logic [27:0] a);
    req_v = 1; req_write = 0; req_addr = a;
    #1 chk("rd_req_ready", req_ready_o, 1);
    step();
    req_v = 0;
    #1;
    chk("rd_app_en", app_en_o, 1);
    chk("rd_app_cmd", app_cmd_o, 3'b001);
    chk("rd_app_addr", app_addr_o, a);
    step();
  endtask

  task automatic rd_beat(input logic [31:0] d, input logic e, input bit expect_kept);
    rd_valid = 1; rd_data = d; rd_end = e;
    if (expect_kept) rq.push_back({e, d});
    step();
    rd_valid = 0;
  endtask

  task automatic check_head();
    logic [32:0] exp;
    chk("rdata_v", rdata_v_o, 1);
    if (rq.size() == 0) begin
      chk("rq_empty", 1, 0);
    end else begin
      exp = rq.pop_front();
      chk("rdata", {rdata_last_o, rdata_o}, exp);
    end
  endtask

  task automatic pop_read();
    check_head();
    rdata_yumi = 1;
    step();
    rdata_yumi = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1;
    req_v = 0; req_write = 0; req_addr = '0;
    wdata_v = 0; wdata = '0; wmask = '0;
    rdata_yumi = 0;
    app_rdy = 1; app_wdf_rdy = 1;
    rd_valid = 0; rd_end = 0; rd_data = '0;
    #2;
    chk("rst_app_en", app_en_o, 0);
    chk("rst_app_addr", app_addr_o, 0);
    chk("rst_rdata_v", rdata_v_o, 0);
    chk("rst_overflow", rd_overflow_o, 0);
    repeat (2) @(posedge clk);
    #1 reset = 0;
    #1;
    chk("rst_req_ready", req_ready_o, 1);
    chk("rst_credits", dut.credits_r, 4);
    step();

    // Basic write burst.
    do_write(28'h100, 32'hA5A5A5A5, 32'h5A5A5A5A, 4'b0000);

    // Command stall: app_rdy low for 5 cycles.
    app_rdy = 0;
    req_v = 1; req_write = 0; req_addr = 28'h40;
    #1 chk("stall_req_ready", req_ready_o, 1);
    step();
    req_v = 0;
    for (int i = 0; i < 6; i++) begin
      if (i == 5) app_rdy = 1;
      #1;
      chk("stall_app_en", app_en_o, 1);
      chk("stall_app_addr", app_addr_o, 28'h40);
      chk("stall_app_cmd", app_cmd_o, 3'b001);
      chk("stall_req_ready", req_ready_o, 0);
      step();
    end
    chk("stall_en_drop", app_en_o, 0);
    rd_beat(32'h11110000, 0, 1);
    rd_beat(32'h11110001, 1, 1);
    pop_read();
    pop_read();
    chk("stall_credits", dut.credits_r, 4);

    // Credit exhaustion.
    issue_read(28'h10);
    chk("cred_ready_after1", req_ready_o, 1);
    issue_read(28'h20);
    chk("cred_ready_after2", req_ready_o, 0);
    rd_beat(32'h22220000, 0, 1);
    rd_beat(32'h22220001, 1, 1);
    rd_beat(32'h33330000, 0, 1);
    rd_beat(32'h33330001, 1, 1);
    chk("cred_full_ready", req_ready_o, 0);
    chk("cred_zero", dut.credits_r, 0);
    pop_read();
    chk("cred_one_yumi", req_ready_o, 0);
    pop_read();
    chk("cred_two_yumi", req_ready_o, 1);

    // Simultaneous reserve and yumi with credits = 2.
    check_head();
    rdata_yumi = 1;
    req_v = 1; req_write = 0; req_addr = 28'h80;
    step();
    rdata_yumi = 0; req_v = 0;
    chk("simul_credits", dut.credits_r, 1);
    chk("simul_app_en", app_en_o, 1);
    step();
    chk("simul_ready_low", req_ready_o, 0);
    pop_read();
    chk("simul_ready_back", req_ready_o, 1);
    rd_beat(32'h44440000, 0, 1);
    rd_beat(32'h44440001, 1, 1);
    pop_read();
    pop_read();
    chk("simul_credits_end", dut.credits_r, 4);

    // Overflow injection.
    issue_read(28'h300);
    issue_read(28'h340);
    rd_beat(32'h55550000, 0, 1);
    rd_beat(32'h55550001, 1, 1);
    rd_beat(32'h66660000, 0, 1);
    rd_beat(32'h66660001, 1, 1);
    chk("ovf_before", rd_overflow_o, 0);
    rd_beat(32'hDEADBEEF, 1, 0);
    chk("ovf_set", rd_overflow_o, 1);
    for (int i = 0; i < 4; i++) pop_read();
    chk("ovf_5th_lost", rdata_v_o, 0);
    chk("ovf_sticky", rd_overflow_o, 1);

    // Async reset mid write burst, after 1 of 2 beats.
    req_v = 1; req_write = 1; req_addr = 28'h180;
    step();
    req_v = 0;
    wdata_v = 1; wdata = 32'h12345678; wmask = 4'h0;
    step();
    chk("rstw_first_wren", app_wdf_wren_o, 1);
    step();
    wdata = 32'h9ABCDEF0;
    #1 chk("rstw_second_pending", app_wdf_wren_o, 1);
    reset = 1;
    #1;
    chk("rstw_app_en", app_en_o, 0);
    chk("rstw_wren", app_wdf_wren_o, 0);
    chk("rstw_end", app_wdf_end_o, 0);
    chk("rstw_wdata_ready", wdata_ready_o, 0);
    chk("rstw_wdf_data", app_wdf_data_o, 0);
    chk("rstw_addr", app_addr_o, 0);
    chk("rstw_cmd", app_cmd_o, 0);
    chk("rstw_overflow", rd_overflow_o, 0);
    chk("rstw_credits", dut.credits_r, 4);
    wdata_v = 0;
    step();
    reset = 0;
    step();
    do_write(28'h200, 32'hCAFEF00D, 32'h0BADBEEF, 4'b0101);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
